cam_capture_rgb444: RTL

Capture stage between the OV7670 camera port and the dual-port frame buffer. It samples the camera's 8-bit RGB444 byte stream (two bytes per pixel) using CAM_vsync and CAM_href framing. It assembles 12-bit pixels and issues single-cycle write strobes with row-aligned addresses into the 160x120 DP RAM. The VGA driver reads that RAM on its own port.

---
 rtl/cam_pkg.sv | 17 +
 rtl/cam_capture_rgb444.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - frame geometry, bus widths and capture FSM encoding
package cam_pkg;
  localparam int IMG_W     = 160;
  localparam int IMG_H     = 120;
  localparam int AW        = 15;
  localparam int DW        = 12;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int CW        = $clog2(IMG_W + 1);
  localparam int RW        = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    IDLE_LINE  = 2'd1,
    CAP_HI     = 2'd2,
    CAP_LO     = 2'd3
  } cap_state_e;
endpackage

// File: rtl/cam_capture_rgb444.sv
// rtl/cam_capture_rgb444.sv - OV7670 RGB444 byte-pair capture into a row-major frame buffer
module cam_capture_rgb444
  import cam_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_done,
  output logic          line_err
);
  localparam logic [CW-1:0] COL_END   = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_END   = RW'(IMG_H);
  localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W);
  localparam logic [AW-1:0] FRAME_END = AW'(FRAME_PIX);

  cap_state_e    state, state_d;
  logic          vsync_q;
  logic [3:0]    r_lat;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] line_base;
  logic          wr_pend;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic          vs_rise, vs_fall, wr_ok;
  logic          take_r, take_px, line_end, err, frame_start, frame_end;

  assign vs_rise = CAM_vsync & ~vsync_q;
  assign vs_fall = ~CAM_vsync & vsync_q;
  // line_base tracks row*IMG_W, so this also blocks rows past the last one
  assign wr_ok   = (col < COL_END) && (line_base < FRAME_END);

  always_comb begin
    state_d     = state;
    take_r      = 1'b0;
    take_px     = 1'b0;
    line_end    = 1'b0;
    err         = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    if (state == WAIT_FRAME) begin
      if (vs_fall) begin
        frame_start = 1'b1;
        state_d     = IDLE_LINE;
      end
    end else if (vs_rise) begin
      frame_end = 1'b1;
      state_d   = WAIT_FRAME;
    end else begin
      case (state)
        IDLE_LINE: if (CAM_href && !CAM_vsync) begin
          take_r  = 1'b1;
          state_d = CAP_LO;
        end
        CAP_HI: if (!CAM_href) begin
          line_end = 1'b1;
          state_d  = IDLE_LINE;
        end else begin
          take_r  = 1'b1;
          state_d = CAP_LO;
        end
        CAP_LO: if (!CAM_href) begin
          line_end = 1'b1;
          err      = 1'b1;
          state_d  = IDLE_LINE;
        end else begin
          take_px = 1'b1;
          state_d = CAP_HI;
        end
        default: state_d = WAIT_FRAME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= WAIT_FRAME;
      vsync_q        <= 1'b0;
      r_lat          <= '0;
      col            <= '0;
      row            <= '0;
      line_base      <= '0;
      wr_pend        <= 1'b0;
      pend_addr      <= '0;
      pend_data      <= '0;
      DP_RAM_regW    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      frame_done     <= 1'b0;
      line_err       <= 1'b0;
    end else begin
      state       <= state_d;
      vsync_q     <= CAM_vsync;
      frame_done  <= frame_end && (row != '0);
      line_err    <= err;
      // staged write lands one edge later, independent of the FSM's fate
      DP_RAM_regW <= wr_pend;
      if (wr_pend) begin
        DP_RAM_addr_in <= pend_addr;
        DP_RAM_data_in <= pend_data;
      end
      wr_pend <= 1'b0;
      if (frame_start) begin
        row       <= '0;
        col       <= '0;
        line_base <= '0;
      end
      if (take_r) r_lat <= CAM_px_data[3:0];
      if (take_px && wr_ok) begin
        wr_pend   <= 1'b1;
        pend_addr <= line_base + AW'(col);
        pend_data <= {r_lat, CAM_px_data};
        col       <= col + CW'(1);
      end
      if (line_end) begin
        col <= '0;
        if (row < ROW_END) begin
          row       <= row + RW'(1);
          line_base <= line_base + LINE_STEP;
        end
      end
    end
  end
endmodule
